// File: rtl/pc_sequencer.sv
// Instruction sequencer: owns PC D/enable and walks IDLE/INIT/FETCH/EXEC/WAIT/HALT.
// PC updates land one half-cycle after each rising edge; FETCH stalls on mem_ready, WAIT stalls on exec_done.
module pc_sequencer #(
  parameter logic [15:0] RESET_VECTOR  = 16'h3000,
  parameter logic [7:0]  HALT_TRAPVECT = 8'h25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] pc_q,
  output logic [15:0] pc_d,
  output logic        pc_en,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_data,
  input  logic [2:0]  nzp,
  output logic [2:0]  base_sel,
  input  logic [15:0] base_val,
  output logic        link_we,
  output logic [15:0] link_val,
  output logic        exec_start,
  input  logic        exec_done,
  output logic [15:0] ir,
  output logic        busy,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_FETCH = 3'd2,
    S_EXEC  = 3'd3,
    S_WAIT  = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        busy_q, halted_q;

  logic [3:0]  opcode;
  logic [15:0] off9, off11;
  logic        br_taken;
  logic        is_halt_trap;

  assign opcode       = ir_q[15:12];
  assign off9         = {{7{ir_q[8]}}, ir_q[8:0]};
  assign off11        = {{5{ir_q[10]}}, ir_q[10:0]};
  assign br_taken     = |(ir_q[11:9] & nzp);
  assign is_halt_trap = (ir_q[7:0] == HALT_TRAPVECT);

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    pc_d       = 16'h0000;
    pc_en      = 1'b0;
    link_we    = 1'b0;
    exec_start = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        pc_en   = 1'b1;
        pc_d    = RESET_VECTOR;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_data;
          pc_en   = 1'b1;
          pc_d    = pc_q + 16'd1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // pc_q already holds the incremented PC here.
        state_d = S_FETCH;
        case (opcode)
          OP_BR: begin
            pc_en = br_taken;
            pc_d  = pc_q + off9;
          end
          OP_JMP: begin
            pc_en = 1'b1;
            pc_d  = base_val;
          end
          OP_JSR: begin
            link_we = 1'b1;
            pc_en   = 1'b1;
            pc_d    = ir_q[11] ? (pc_q + off11) : base_val;
          end
          OP_TRAP: begin
            if (is_halt_trap) begin
              state_d = S_HALT;
            end else begin
              link_we = 1'b1;
              pc_en   = 1'b1;
              pc_d    = {8'h00, ir_q[7:0]};
            end
          end
          default: begin
            exec_start = 1'b1;
            state_d    = S_WAIT;
          end
        endcase
      end
      S_WAIT: begin
        if (exec_done) state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Reset overrides everything, including a fetch completing this cycle.
    if (reset) begin
      state_d    = S_IDLE;
      ir_d       = 16'h0000;
      pc_d       = 16'h0000;
      pc_en      = 1'b0;
      link_we    = 1'b0;
      exec_start = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ir_q     <= 16'h0000;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      busy_q   <= (state_d != S_IDLE) && (state_d != S_HALT);
      halted_q <= (state_d == S_HALT);
    end
  end

  assign mem_req  = (state_q == S_FETCH) && !reset;
  assign mem_addr = mem_req ? pc_q : 16'h0000;
  assign base_sel = ir_q[8:6];
  assign link_val = pc_q;
  assign ir       = ir_q;
  assign busy     = busy_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: hosts the PC register and memory, checks against an ISA-level model.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] pc_reg;
  logic [15:0] pc_d;
  logic        pc_en;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_data;
  logic [2:0]  nzp;
  logic [2:0]  base_sel;
  logic [15:0] base_val;
  logic        link_we;
  logic [15:0] link_val;
  logic        exec_start;
  logic        exec_done;
  logic [15:0] ir;
  logic        busy;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] m_pc;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .pc_q(pc_reg), .pc_d(pc_d), .pc_en(pc_en),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
    .nzp(nzp), .base_sel(base_sel), .base_val(base_val),
    .link_we(link_we), .link_val(link_val),
    .exec_start(exec_start), .exec_done(exec_done),
    .ir(ir), .busy(busy), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial pc_reg = 16'h0000;
  always @(negedge clk) if (pc_en) pc_reg <= pc_d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction end to end: fetch with mlat stall cycles, execute, and xlat datapath cycles if handed off.
  task automatic run_instr(input logic [15:0] instr, input logic [2:0] cc, input logic [15:0] base,
                           input int mlat, input int xlat);
    logic [3:0]  op;
    logic        exp_en, exp_link, exp_xs;
    logic [15:0] exp_pcd;
    int          off;
    int          kind;   // 0 next fetch, 1 datapath wait, 2 halt
    for (int i = 0; i < mlat; i++) begin
      mem_ready = 1'b0;
      exec_done = 1'($urandom_range(1));
      start     = 1'($urandom_range(1));
      #1;
      chk("fetch_req", mem_req, 1);
      chk("fetch_addr", mem_addr, m_pc);
      chk("fetch_stall_pcen", pc_en, 0);
      tick();
    end
    mem_ready = 1'b1;
    mem_data  = instr;
    exec_done = 1'b0;
    start     = 1'b0;
    #1;
    chk("fetch_req", mem_req, 1);
    chk("fetch_addr", mem_addr, m_pc);
    chk("fetch_pcen", pc_en, 1);
    chk("fetch_pcd", pc_d, 16'(m_pc + 16'd1));
    tick();
    m_pc = 16'(m_pc + 16'd1);

    mem_ready = 1'($urandom_range(1));
    mem_data  = 16'($urandom);
    exec_done = 1'($urandom_range(1));
    nzp       = cc;
    base_val  = base;
    op = instr[15:12];
    exp_en = 1'b0; exp_link = 1'b0; exp_xs = 1'b0; exp_pcd = 16'h0000; kind = 0;
    case (op)
      4'b0000: begin
        off = instr[8] ? int'(instr[8:0]) - 512 : int'(instr[8:0]);
        exp_pcd = 16'(int'(m_pc) + off);
        exp_en  = (instr[11] & cc[2]) | (instr[10] & cc[1]) | (instr[9] & cc[0]);
      end
      4'b1100: begin
        exp_en = 1'b1; exp_pcd = base;
      end
      4'b0100: begin
        off = instr[10] ? int'(instr[10:0]) - 2048 : int'(instr[10:0]);
        exp_en = 1'b1; exp_link = 1'b1;
        exp_pcd = instr[11] ? 16'(int'(m_pc) + off) : base;
      end
      4'b1111: begin
        if (instr[7:0] == 8'h25) kind = 2;
        else begin
          exp_en = 1'b1; exp_link = 1'b1; exp_pcd = {8'h00, instr[7:0]};
        end
      end
      default: begin
        exp_xs = 1'b1; kind = 1;
      end
    endcase
    #1;
    chk("exec_ir", ir, instr);
    chk("exec_base_sel", base_sel, instr[8:6]);
    chk("exec_pcen", pc_en, exp_en);
    if (exp_en) chk("exec_pcd", pc_d, exp_pcd);
    chk("exec_link_we", link_we, exp_link);
    if (exp_link) chk("exec_link_val", link_val, m_pc);
    chk("exec_start", exec_start, exp_xs);
    chk("exec_mem_req", mem_req, 0);
    chk("exec_busy", busy, 1);
    tick();
    if (exp_en) m_pc = exp_pcd;
    mem_ready = 1'b0;
    exec_done = 1'b0;

    if (kind == 1) begin
      for (int i = 0; i < xlat; i++) begin
        #1;
        chk("wait_busy", busy, 1);
        chk("wait_req", mem_req, 0);
        chk("wait_xs", exec_start, 0);
        chk("wait_pcen", pc_en, 0);
        tick();
      end
      exec_done = 1'b1;
      #1;
      chk("wait_busy", busy, 1);
      tick();
      exec_done = 1'b0;
    end else if (kind == 2) begin
      #1;
      chk("halt_halted", halted, 1);
      chk("halt_busy", busy, 0);
    end
  endtask

  initial begin
    logic [15:0] r;
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; mem_data = 16'h0000;
    nzp = 3'b000; base_val = 16'h0000; exec_done = 1'b0;
    tick(); tick();
    mem_ready = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pcen", pc_en, 0);
    chk("rst_pcd", pc_d, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_xs", exec_start, 0);
    chk("rst_link", link_we, 0);
    chk("rst_ir", ir, 0);
    tick();

    reset = 1'b0; mem_ready = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_req", mem_req, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("init_pcen", pc_en, 1);
    chk("init_pcd", pc_d, 16'h3000);
    chk("init_busy", busy, 1);
    tick();
    m_pc = 16'h3000;
    chk("init_pc_loaded", pc_reg, 16'h3000);

    run_instr(16'h1042, 3'b000, 16'h0000, 1, 2);
    chk("add_pc", pc_reg, 16'h3001);
    run_instr(16'hC040, 3'b000, 16'h3005, 0, 0);
    run_instr(16'h05FE, 3'b010, 16'h0000, 2, 0);
    chk("brz_taken_pc", pc_reg, 16'h3004);
    run_instr(16'hC040, 3'b000, 16'h3005, 0, 0);
    run_instr(16'h05FE, 3'b001, 16'h0000, 0, 0);
    chk("brz_not_taken_pc", pc_reg, 16'h3006);
    run_instr(16'hC040, 3'b000, 16'h4000, 0, 0);
    run_instr(16'h4810, 3'b000, 16'h0000, 1, 0);
    chk("jsr_pc", pc_reg, 16'h4011);
    run_instr(16'hC1C0, 3'b000, 16'h4001, 0, 0);
    chk("ret_pc", pc_reg, 16'h4001);
    run_instr(16'hC040, 3'b000, 16'hFFFF, 0, 0);
    run_instr(16'h0000, 3'b111, 16'h1234, 0, 0);
    chk("wrap_pc", pc_reg, 16'h0000);

    for (int k = 0; k < 150; k++) begin
      r = 16'($urandom);
      if (r[15:12] == 4'hF && r[7:0] == 8'h25) r[7:0] = 8'h26;
      run_instr(r, 3'($urandom_range(7)), 16'($urandom),
                $urandom_range(3), $urandom_range(3));
    end
    chk("random_pc_track", pc_reg, m_pc);

    run_instr(16'hF025, 3'b000, 16'h0000, 1, 0);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; mem_ready = 1'b1; exec_done = 1'b1;
      #1;
      chk("halt_stays", halted, 1);
      chk("halt_not_busy", busy, 0);
      chk("halt_req", mem_req, 0);
      chk("halt_pcen", pc_en, 0);
      tick();
    end
    start = 1'b0; mem_ready = 1'b0; exec_done = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("halt_reset_halted", halted, 0);
    chk("halt_reset_busy", busy, 0);
    tick();

    // Reset while waiting on the datapath.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    mem_ready = 1'b1; mem_data = 16'h1042;
    tick();
    mem_ready = 1'b0;
    tick();
    reset = 1'b1; exec_done = 1'b1;
    #1;
    chk("rst_wait_xs", exec_start, 0);
    chk("rst_wait_pcen", pc_en, 0);
    tick();
    reset = 1'b0; exec_done = 1'b0;
    #1;
    chk("rst_wait_busy", busy, 0);
    chk("rst_wait_ir", ir, 0);
    tick();

    // Reset colliding with a completing fetch.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #1;
    chk("refetch_req", mem_req, 1);
    reset = 1'b1; mem_ready = 1'b1; mem_data = 16'hF025;
    #1;
    chk("rst_fetch_req", mem_req, 0);
    chk("rst_fetch_pcen", pc_en, 0);
    chk("rst_fetch_pcd", pc_d, 0);
    tick();
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    chk("rst_fetch_ir", ir, 0);
    chk("rst_fetch_busy", busy, 0);
    chk("rst_fetch_halted", halted, 0);
    tick();
    #1;
    chk("rst_fetch_idle", busy, 0);
    chk("rst_fetch_idle_req", mem_req, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
